// File: rtl/wb_stage_lsu_pkg.sv
// Instruction-definition constants and stage state type shared by the
// writeback stage and its load-extraction helper.
package wb_stage_lsu_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic {
    S_IDLE     = 1'b0,
    S_WAIT_MEM = 1'b1
  } state_t;

  function automatic logic op_writes_rd(input logic [6:0] op);
    return (op == OPC_OP)  || (op == OPC_OPIMM) || (op == OPC_JALR) ||
           (op == OPC_LOAD) || (op == OPC_LUI) || (op == OPC_AUIPC) ||
           (op == OPC_JAL);
  endfunction

endpackage

// File: rtl/wb_stage_lsu_load_extend.sv
// Combinational load-data extraction: picks the byte/half lane from the
// aligned word by address low bits and sign/zero-extends by funct3.
module load_extend
  import wb_stage_lsu_pkg::*;
(
  input  logic [2:0]  funct3_i,
  input  logic [1:0]  addr_i,
  input  logic [31:0] word_i,
  output logic [31:0] data_o
);

  logic [31:0] w_shifted;
  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    w_shifted = word_i >> {addr_i, 3'b000};
    w_byte    = w_shifted[7:0];
    // Half lane ignores addr[0]; misaligned halves are an upstream concern.
    w_half    = addr_i[1] ? word_i[31:16] : word_i[15:0];
    case (funct3_i)
      F3_LB:   data_o = {{24{w_byte[7]}}, w_byte};
      F3_LBU:  data_o = {24'h000000, w_byte};
      F3_LH:   data_o = {{16{w_half[15]}}, w_half};
      F3_LHU:  data_o = {16'h0000, w_half};
      F3_LW:   data_o = word_i;
      default: data_o = word_i;
    endcase
  end

endmodule

// File: rtl/wb_stage_lsu.sv
// Writeback stage with load completion: registers the RF write port, waits on
// memory for loads with a bounded timeout, and counts retired instructions.
module wb_stage_lsu
  import wb_stage_lsu_pkg::*;
#(
  parameter int unsigned CNT_W   = 64,
  parameter int unsigned TO_W    = 8,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      result_i,
  input  logic             mem_rvalid_i,
  input  logic [31:0]      mem_rdata_i,
  output logic             rdvalid_o,
  output logic [4:0]       rdnum_o,
  output logic [31:0]      rddata_o,
  output logic             retire_o,
  output logic [CNT_W-1:0] instret_o,
  output logic             fault_o,
  output logic [31:0]      fault_pc_o
);

  state_t            r_state;
  logic [4:0]        r_ld_rd;
  logic [2:0]        r_ld_f3;
  logic [1:0]        r_ld_addr;
  logic [31:0]       r_ld_pc;
  logic [TO_W-1:0]   r_cnt;
  logic              r_rdvalid;
  logic [4:0]        r_rdnum;
  logic [31:0]       r_rddata;
  logic              r_retire;
  logic [CNT_W-1:0]  r_instret;
  logic              r_fault;
  logic [31:0]       r_fault_pc;

  logic [6:0]        w_op;
  logic [4:0]        w_rd;
  logic [2:0]        w_f3;
  logic              w_accept;
  logic [31:0]       w_ld_data;
  logic              w_unused_inst;

  assign w_op          = inst_i[6:0];
  assign w_rd          = inst_i[11:7];
  assign w_f3          = inst_i[14:12];
  assign w_unused_inst = ^inst_i[31:15];
  assign w_accept      = valid_i && (r_state == S_IDLE);

  load_extend u_load_extend (
    .funct3_i (r_ld_f3),
    .addr_i   (r_ld_addr),
    .word_i   (mem_rdata_i),
    .data_o   (w_ld_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_ld_rd    <= '0;
      r_ld_f3    <= '0;
      r_ld_addr  <= '0;
      r_ld_pc    <= '0;
      r_cnt      <= '0;
      r_rdvalid  <= 1'b0;
      r_rdnum    <= '0;
      r_rddata   <= '0;
      r_retire   <= 1'b0;
      r_instret  <= '0;
      r_fault    <= 1'b0;
      r_fault_pc <= '0;
    end else begin
      r_rdvalid <= 1'b0;
      r_retire  <= 1'b0;
      r_fault   <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            if (w_op == OPC_LOAD) begin
              r_ld_rd   <= w_rd;
              r_ld_f3   <= w_f3;
              r_ld_addr <= result_i[1:0];
              r_ld_pc   <= pc_i;
              r_cnt     <= '0;
              r_state   <= S_WAIT_MEM;
            end else begin
              r_retire  <= 1'b1;
              r_instret <= r_instret + 1'b1;
              if (op_writes_rd(w_op) && (w_rd != 5'd0)) begin
                r_rdvalid <= 1'b1;
                r_rdnum   <= w_rd;
                r_rddata  <= result_i;
              end
            end
          end
        end
        S_WAIT_MEM: begin
          // Data arriving on the final timeout cycle takes priority over the fault.
          if (mem_rvalid_i) begin
            r_retire  <= 1'b1;
            r_instret <= r_instret + 1'b1;
            r_state   <= S_IDLE;
            if (r_ld_rd != 5'd0) begin
              r_rdvalid <= 1'b1;
              r_rdnum   <= r_ld_rd;
              r_rddata  <= w_ld_data;
            end
          end else if (r_cnt == TO_W'(TIMEOUT - 1)) begin
            r_fault    <= 1'b1;
            r_fault_pc <= r_ld_pc;
            r_state    <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ready_o    = (r_state == S_IDLE);
  assign rdvalid_o  = r_rdvalid;
  assign rdnum_o    = r_rdnum;
  assign rddata_o   = r_rddata;
  assign retire_o   = r_retire;
  assign instret_o  = r_instret;
  assign fault_o    = r_fault;
  assign fault_pc_o = r_fault_pc;

endmodule

// File: tb/tb_wb_stage_lsu.sv
// Bench for wb_stage_lsu: directed scenarios then random traffic, each cycle
// compared against a behavioural model of the writeback/load rules.
module tb_wb_stage_lsu;

  localparam int unsigned CW = 4;
  localparam int unsigned TO = 4;

  localparam logic [6:0] T_OP     = 7'b0110011;
  localparam logic [6:0] T_OPIMM  = 7'b0010011;
  localparam logic [6:0] T_JALR   = 7'b1100111;
  localparam logic [6:0] T_LOAD   = 7'b0000011;
  localparam logic [6:0] T_LUI    = 7'b0110111;
  localparam logic [6:0] T_AUIPC  = 7'b0010111;
  localparam logic [6:0] T_JAL    = 7'b1101111;
  localparam logic [6:0] T_STORE  = 7'b0100011;
  localparam logic [6:0] T_BRANCH = 7'b1100011;
  localparam logic [6:0] T_SYSTEM = 7'b1110011;
  localparam logic [6:0] T_FENCE  = 7'b0001111;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [31:0]   pc_i = '0;
  logic [31:0]   inst_i = '0;
  logic [31:0]   result_i = '0;
  logic          mem_rvalid_i = 1'b0;
  logic [31:0]   mem_rdata_i = '0;
  logic          rdvalid_o;
  logic [4:0]    rdnum_o;
  logic [31:0]   rddata_o;
  logic          retire_o;
  logic [CW-1:0] instret_o;
  logic          fault_o;
  logic [31:0]   fault_pc_o;

  always #5 clk = ~clk;

  wb_stage_lsu #(.CNT_W(CW), .TO_W(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o), .pc_i(pc_i),
    .inst_i(inst_i), .result_i(result_i), .mem_rvalid_i(mem_rvalid_i),
    .mem_rdata_i(mem_rdata_i), .rdvalid_o(rdvalid_o), .rdnum_o(rdnum_o),
    .rddata_o(rddata_o), .retire_o(retire_o), .instret_o(instret_o),
    .fault_o(fault_o), .fault_pc_o(fault_pc_o)
  );

  int n_checks = 0;
  int n_fail   = 0;

  bit          m_busy;
  int          m_waited;
  logic [4:0]  m_rd;
  logic [2:0]  m_f3;
  logic [1:0]  m_a;
  logic [31:0] m_pc;
  logic        e_rdvalid, e_retire, e_fault;
  logic [4:0]  e_rdnum;
  logic [31:0] e_rddata, e_fault_pc;
  int          e_instret;

  function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd, input logic [2:0] f3);
    return {17'd0, f3, rd, op};
  endfunction

  function automatic bit writes(input logic [6:0] op);
    return op inside {T_OP, T_OPIMM, T_JALR, T_LOAD, T_LUI, T_AUIPC, T_JAL};
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [1:0] a, input logic [31:0] w);
    longint v;
    int     sh;
    sh = 8 * int'(a);
    case (f3)
      3'd0, 3'd4: begin
        v = longint'((w >> sh) & 32'hFF);
        if (f3 == 3'd0 && v >= 128) v = v - 256;
      end
      3'd1, 3'd5: begin
        v = longint'((w >> (a[1] ? 16 : 0)) & 32'hFFFF);
        if (f3 == 3'd1 && v >= 32768) v = v - 65536;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  task automatic model_reset();
    m_busy = 0; m_waited = 0; m_rd = '0; m_f3 = '0; m_a = '0; m_pc = '0;
    e_rdvalid = 0; e_retire = 0; e_fault = 0; e_rdnum = '0; e_rddata = '0;
    e_fault_pc = '0; e_instret = 0;
  endtask

  task automatic model_edge();
    e_rdvalid = 0; e_retire = 0; e_fault = 0;
    if (!m_busy) begin
      if (valid_i) begin
        if (inst_i[6:0] == T_LOAD) begin
          m_busy = 1; m_waited = 0; m_rd = inst_i[11:7]; m_f3 = inst_i[14:12];
          m_a = result_i[1:0]; m_pc = pc_i;
        end else begin
          e_retire = 1;
          if (writes(inst_i[6:0]) && inst_i[11:7] != 5'd0) begin
            e_rdvalid = 1; e_rdnum = inst_i[11:7]; e_rddata = result_i;
          end
        end
      end
    end else if (mem_rvalid_i) begin
      m_busy = 0; e_retire = 1;
      if (m_rd != 5'd0) begin
        e_rdvalid = 1; e_rdnum = m_rd; e_rddata = ref_load(m_f3, m_a, mem_rdata_i);
      end
    end else begin
      m_waited++;
      if (m_waited == int'(TO)) begin
        m_busy = 0; e_fault = 1; e_fault_pc = m_pc;
      end
    end
    if (e_retire) e_instret = (e_instret + 1) % (1 << CW);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"},    64'(ready_o),    64'(!m_busy));
    chk({tag, ".rdvalid"},  64'(rdvalid_o),  64'(e_rdvalid));
    chk({tag, ".rdnum"},    64'(rdnum_o),    64'(e_rdnum));
    chk({tag, ".rddata"},   64'(rddata_o),   64'(e_rddata));
    chk({tag, ".retire"},   64'(retire_o),   64'(e_retire));
    chk({tag, ".instret"},  64'(instret_o),  64'(e_instret));
    chk({tag, ".fault"},    64'(fault_o),    64'(e_fault));
    chk({tag, ".fault_pc"}, 64'(fault_pc_o), 64'(e_fault_pc));
  endtask

  task automatic cyc(input string tag);
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all(tag);
  endtask

  task automatic send(input logic [31:0] inst, input logic [31:0] res, input logic [31:0] pc);
    valid_i = 1'b1; inst_i = inst; result_i = res; pc_i = pc;
  endtask

  task automatic do_load(input string tag, input logic [2:0] f3, input logic [4:0] rd,
                         input logic [31:0] addr, input int waits, input logic [31:0] rdata);
    send(mk(T_LOAD, rd, f3), addr, 32'h0000_4000 + addr);
    cyc({tag, ".acc"});
    valid_i = 1'b0;
    for (int i = 0; i < waits; i++) cyc({tag, ".wait"});
    mem_rvalid_i = 1'b1; mem_rdata_i = rdata;
    cyc({tag, ".data"});
    mem_rvalid_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [6:0] ops [11];
    logic [6:0] op;
    ops = '{T_OP, T_OPIMM, T_JALR, T_LOAD, T_LUI, T_AUIPC, T_JAL,
            T_STORE, T_BRANCH, T_SYSTEM, T_FENCE};
    model_reset();
    @(negedge clk);
    check_all("reset");
    @(negedge clk);
    rst = 1'b0;

    send(mk(T_OPIMM, 5'd5, 3'd0), 32'h0000_1234, 32'h100);
    cyc("addi");
    valid_i = 1'b0;
    chk("addi.const_data", 64'(rddata_o), 64'h1234);
    chk("addi.const_instret", 64'(instret_o), 64'd1);

    // LB/LBU at byte 3, data on the fourth WAIT_MEM cycle (the timeout cycle).
    do_load("lb", 3'b000, 5'd6, 32'h0000_2003, 3, 32'h80FF_0000);
    chk("lb.const_data", 64'(rddata_o), 64'hFFFF_FF80);
    chk("lb.const_nofault", 64'(fault_o), 64'd0);
    do_load("lbu", 3'b100, 5'd6, 32'h0000_2003, 3, 32'h80FF_0000);
    chk("lbu.const_data", 64'(rddata_o), 64'h0000_0080);
    do_load("lh", 3'b001, 5'd9, 32'h0000_2002, 1, 32'h8001_7FFF);
    chk("lh.const_data", 64'(rddata_o), 64'hFFFF_8001);
    do_load("lhu", 3'b101, 5'd9, 32'h0000_2002, 0, 32'h8001_7FFF);
    chk("lhu.const_data", 64'(rddata_o), 64'h0000_8001);
    do_load("lw", 3'b010, 5'd10, 32'h0000_2000, 2, 32'hDEAD_BEEF);
    do_load("lw_x0", 3'b010, 5'd0, 32'h0000_2000, 0, 32'h1111_2222);

    send(mk(T_LOAD, 5'd11, 3'b010), 32'h0000_3000, 32'h0000_ABC0);
    cyc("to.acc");
    valid_i = 1'b0;
    for (int i = 0; i < int'(TO); i++) cyc("to.wait");
    chk("to.const_fault", 64'(fault_o), 64'd1);
    chk("to.const_pc", 64'(fault_pc_o), 64'h0000_ABC0);
    cyc("to.after");

    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h5555_5555;
    cyc("idle_rvalid");
    mem_rvalid_i = 1'b0;

    send(mk(T_OP, 5'd0, 3'd0), 32'h1, 32'h200);
    cyc("b2b.add_x0");
    send(mk(T_STORE, 5'd3, 3'd2), 32'h2, 32'h204);
    cyc("b2b.sw");
    send(mk(T_JAL, 5'd1, 3'd0), 32'h20C, 32'h208);
    cyc("b2b.jal");
    valid_i = 1'b0;

    send(mk(T_LOAD, 5'd7, 3'b010), 32'h0000_5000, 32'h0000_7770);
    cyc("rst.acc");
    valid_i = 1'b0;
    cyc("rst.wait");
    rst = 1'b1;
    #2;
    model_reset();
    check_all("rst.mid");
    @(negedge clk);
    rst = 1'b0;
    mem_rvalid_i = 1'b1; mem_rdata_i = 32'h7777_7777;
    cyc("rst.late_rvalid");
    mem_rvalid_i = 1'b0;

    for (int i = 0; i < 600; i++) begin
      op = ops[$urandom_range(0, 10)];
      valid_i      = ($urandom_range(0, 1) == 1);
      inst_i       = mk(op, 5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)));
      result_i     = $urandom;
      pc_i         = $urandom;
      mem_rvalid_i = ($urandom_range(0, 2) == 0);
      mem_rdata_i  = $urandom;
      cyc("rand");
    end
    valid_i = 1'b0; mem_rvalid_i = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
